// File: rtl/cpu_pkg.sv
// Shared CPU constants: write-size encodings and default register-file geometry.
package cpu_pkg;

  localparam int REG_NUM_DEFAULT   = 32;
  localparam int REG_WIDTH_DEFAULT = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits with reserve-over-clear priority and a registered
// population count that is updated on the same edge as the busy bits.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter  int REG_NUM = REG_NUM_DEFAULT,
  localparam int AW      = $clog2(REG_NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_en_i,
  input  logic [AW-1:0]      set_addr_i,
  input  logic               clr_en_i,
  input  logic [AW-1:0]      clr_addr_i,
  output logic [REG_NUM-1:0] busy_o,
  output logic [AW:0]        busy_count_o
);

  logic [REG_NUM-1:0] busy_q, busy_d;
  logic [AW:0]        count_q, count_d;

  // NOTE: every comb output is given a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
    // A reserve issued alongside the writeback of the same register means a
    // new producer is in flight, so the set is applied last and wins.
    if (set_en_i) busy_d[set_addr_i] = 1'b1;
    count_d = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      count_d = count_d + {{AW{1'b0}}, busy_d[i]};
    end
  end

  // NOTE: blocking '=' only in combinational blocks, non-blocking '<=' only for flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_o       = busy_q;
  assign busy_count_o = count_q;

endmodule

// File: rtl/register_bank.sv
// CPU register file: sized merging writes, N read ports with write bypass and a
// busy scoreboard. Define REG_BANK_ZERO_HARDWIRED_EN to hardwire register 0 to zero.
module register_bank
  import cpu_pkg::*;
#(
  parameter  int REG_NUM    = REG_NUM_DEFAULT,
  parameter  int REG_WIDTH  = REG_WIDTH_DEFAULT,
  parameter  int READ_PORTS = 2,
  localparam int AW         = $clog2(REG_NUM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [READ_PORTS*AW-1:0]        rd_addr,
  output logic [READ_PORTS*REG_WIDTH-1:0] rd_data,
  output logic [READ_PORTS-1:0]           rd_busy,
  input  logic                           wr_en,
  input  logic [1:0]                     wr_size,
  input  logic [AW-1:0]                  wr_addr,
  input  logic [REG_WIDTH-1:0]           wr_data,
  input  logic                           rsv_en,
  input  logic [AW-1:0]                  rsv_addr,
  output logic [AW:0]                    busy_count
);

  logic [REG_WIDTH-1:0] regs_q [REG_NUM];
  logic [REG_WIDTH-1:0] merged_d;
  logic [REG_NUM-1:0]   busy;
  logic                 wr_valid;
  logic                 rsv_valid;

  // Gating by rst keeps a write held across reset from being forwarded.
  always_comb begin
    wr_valid  = wr_en && (wr_size != SIZE_RSVD) && !rst;
    rsv_valid = rsv_en && !rst;
`ifdef REG_BANK_ZERO_HARDWIRED_EN
    if (wr_addr == '0)  wr_valid  = 1'b0;
    if (rsv_addr == '0) rsv_valid = 1'b0;
`endif
  end

  always_comb begin
    case (wr_size)
      SIZE_BYTE: merged_d = {regs_q[wr_addr][REG_WIDTH-1:8], wr_data[7:0]};
      SIZE_HALF: merged_d = {regs_q[wr_addr][REG_WIDTH-1:16], wr_data[15:0]};
      default:   merged_d = wr_data;
    endcase
  end

  // NOTE: the array has an async reset, so it is built from flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else if (wr_valid) begin
      regs_q[wr_addr] <= merged_d;
    end
  end

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;
    assign addr = rd_addr[p*AW +: AW];
    assign hit  = wr_valid && (wr_addr == addr);
    assign rd_data[p*REG_WIDTH +: REG_WIDTH] = hit ? merged_d : regs_q[addr];
    assign rd_busy[p] = busy[addr] && !hit;
  end

  reg_scoreboard #(
    .REG_NUM (REG_NUM)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .set_en_i     (rsv_valid),
    .set_addr_i   (rsv_addr),
    .clr_en_i     (wr_valid),
    .clr_addr_i   (wr_addr),
    .busy_o       (busy),
    .busy_count_o (busy_count)
  );

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank (default 32x32, two read ports).
module tb_register_bank;
  import cpu_pkg::*;

  localparam int N  = 32;
  localparam int W  = 32;
  localparam int RP = 2;
  localparam int AW = 5;

  logic            clk;
  logic            rst;
  logic [RP*AW-1:0] rd_addr;
  logic [RP*W-1:0]  rd_data;
  logic [RP-1:0]    rd_busy;
  logic            wr_en;
  logic [1:0]      wr_size;
  logic [AW-1:0]   wr_addr;
  logic [W-1:0]    wr_data;
  logic            rsv_en;
  logic [AW-1:0]   rsv_addr;
  logic [AW:0]     busy_count;

  register_bank #(.REG_NUM(N), .REG_WIDTH(W), .READ_PORTS(RP)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_size(wr_size), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_count(busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {K_D0, K_D1, K_B0, K_B1, K_CNT} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input kind_e k, input logic [31:0] e);
    exp_t x;
    x.tag = tag; x.kind = k; x.exp = e;
    sb_q.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      case (x.kind)
        K_D0:    obs = rd_data[31:0];
        K_D1:    obs = rd_data[63:32];
        K_B0:    obs = {31'd0, rd_busy[0]};
        K_B1:    obs = {31'd0, rd_busy[1]};
        default: obs = {26'd0, busy_count};
      endcase
      check(x.tag, obs, x.exp);
    end
  endtask

  // Drive one cycle's inputs just after a rising edge.
  task automatic drive(input logic we, input logic [1:0] sz, input int wa, input logic [31:0] wd,
                       input logic re, input int ra, input int a0, input int a1);
    wr_en = we; wr_size = sz; wr_addr = AW'(wa); wr_data = wd;
    rsv_en = re; rsv_addr = AW'(ra);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic idle_read(input int a0, input int a1);
    drive(1'b0, SIZE_WORD, 0, 32'h0, 1'b0, 0, a0, a1);
  endtask

  // Compare mid-cycle, then advance past the next rising edge.
  task automatic tick();
    #2;
    drain();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, SIZE_WORD, 1, 32'hDEAD_BEEF, 1'b1, 1, 1, 2);
    #2;
    expect_val("rst_d0", K_D0, 32'h0);
    expect_val("rst_b0", K_B0, 32'h0);
    expect_val("rst_cnt", K_CNT, 32'h0);
    drain();
    @(posedge clk); #1;
    rst = 1'b0;

    // Word writes, then two-port reads.
    drive(1'b1, SIZE_WORD, 1, 32'h0000_0800, 1'b0, 0, 0, 0); tick();
    drive(1'b1, SIZE_WORD, 5, 32'd50, 1'b0, 0, 0, 0);        tick();
    drive(1'b1, SIZE_WORD, 9, 32'hFFFF_FFF6, 1'b0, 0, 0, 0); tick();
    idle_read(1, 5);
    expect_val("rd_r1", K_D0, 32'h0000_0800);
    expect_val("rd_r5", K_D1, 32'h0000_0032);
    tick();
    idle_read(9, 1);
    expect_val("rd_r9", K_D0, 32'hFFFF_FFF6);
    expect_val("rd_r1_p1", K_D1, 32'h0000_0800);
    tick();

    // Sized merges, each checked through bypass and then from storage.
    drive(1'b1, SIZE_BYTE, 1, 32'hAAAA_AA12, 1'b0, 0, 1, 5);
    expect_val("byte_byp", K_D0, 32'h0000_0812);
    expect_val("byte_other", K_D1, 32'h0000_0032);
    tick();
    drive(1'b1, SIZE_HALF, 1, 32'h5555_ABCD, 1'b0, 0, 5, 1);
    expect_val("half_old", K_D0, 32'h0000_0032);
    expect_val("half_byp", K_D1, 32'h0000_ABCD);
    tick();
    drive(1'b1, SIZE_RSVD, 1, 32'hFFFF_FFFF, 1'b0, 0, 1, 1);
    expect_val("rsvd_nobyp", K_D0, 32'h0000_ABCD);
    tick();
    idle_read(1, 9);
    expect_val("rsvd_kept", K_D0, 32'h0000_ABCD);
    tick();

    // Word bypass on r7.
    drive(1'b1, SIZE_WORD, 7, 32'h1234_5678, 1'b0, 0, 7, 1);
    expect_val("r7_byp", K_D0, 32'h1234_5678);
    tick();
    idle_read(1, 7);
    expect_val("r7_reg", K_D1, 32'h1234_5678);
    tick();

    // Scoreboard: reserve, then writeback clears.
    drive(1'b0, SIZE_WORD, 0, 32'h0, 1'b1, 3, 3, 3);
    expect_val("rsv_same_cyc", K_B0, 32'h0);
    tick();
    idle_read(3, 7);
    expect_val("r3_busy", K_B0, 32'h1);
    expect_val("r7_free", K_B1, 32'h0);
    expect_val("cnt_1", K_CNT, 32'd1);
    tick();
    drive(1'b1, SIZE_WORD, 3, 32'h0000_CAFE, 1'b0, 0, 3, 3);
    expect_val("r3_wb_busy", K_B0, 32'h0);
    expect_val("r3_wb_data", K_D1, 32'h0000_CAFE);
    expect_val("cnt_wb_cyc", K_CNT, 32'd1);
    tick();
    idle_read(3, 3);
    expect_val("cnt_0", K_CNT, 32'd0);
    expect_val("r3_cleared", K_B0, 32'h0);
    tick();

    // Reserve and write to r4 together: data lands, stays busy.
    drive(1'b1, SIZE_WORD, 4, 32'h0000_0044, 1'b1, 4, 4, 3);
    expect_val("r4_byp", K_D0, 32'h0000_0044);
    tick();
    idle_read(4, 3);
    expect_val("r4_data", K_D0, 32'h0000_0044);
    expect_val("r4_busy", K_B0, 32'h1);
    expect_val("cnt_r4", K_CNT, 32'd1);
    tick();

    // Reserve r3 while writing r5: both apply.
    drive(1'b1, SIZE_WORD, 5, 32'h0000_0055, 1'b1, 3, 5, 3);
    tick();
    idle_read(5, 3);
    expect_val("r5_data", K_D0, 32'h0000_0055);
    expect_val("r3_rebusy", K_B1, 32'h1);
    expect_val("cnt_2", K_CNT, 32'd2);
    tick();
    drive(1'b0, SIZE_WORD, 0, 32'h0, 1'b1, 9, 9, 4); tick();
    drive(1'b0, SIZE_WORD, 0, 32'h0, 1'b1, 4, 9, 4); tick();
    drive(1'b1, SIZE_RSVD, 9, 32'h0, 1'b0, 0, 4, 9);
    expect_val("rsvd_busy_kept", K_B1, 32'h1);
    expect_val("cnt_3", K_CNT, 32'd3);
    tick();
    idle_read(9, 4);
    expect_val("cnt_3_again", K_CNT, 32'd3);
    expect_val("r9_before_rst", K_D0, 32'hFFFF_FFF6);
    tick();

    // Asynchronous reset in the middle of a write cycle.
    drive(1'b1, SIZE_WORD, 9, 32'h0000_0999, 1'b0, 0, 9, 4);
    #1;
    rst = 1'b1;
    #1;
    expect_val("arst_d0", K_D0, 32'h0);
    expect_val("arst_d1", K_D1, 32'h0);
    expect_val("arst_b1", K_B1, 32'h0);
    expect_val("arst_cnt", K_CNT, 32'd0);
    drain();
    @(posedge clk); #1;
    rst = 1'b0;
    idle_read(9, 4);
    expect_val("post_rst_r9", K_D0, 32'h0);
    expect_val("post_rst_r4", K_D1, 32'h0);
    tick();

    // Register 0 behaviour depends on the build option.
    drive(1'b1, SIZE_WORD, 0, 32'd10, 1'b1, 0, 0, 0);
`ifdef REG_BANK_ZERO_HARDWIRED_EN
    expect_val("r0_byp", K_D0, 32'h0);
`else
    expect_val("r0_byp", K_D0, 32'd10);
`endif
    tick();
    idle_read(0, 0);
`ifdef REG_BANK_ZERO_HARDWIRED_EN
    expect_val("r0_data", K_D0, 32'h0);
    expect_val("r0_busy", K_B0, 32'h0);
    expect_val("r0_cnt", K_CNT, 32'd0);
`else
    expect_val("r0_data", K_D0, 32'd10);
    expect_val("r0_busy", K_B0, 32'h1);
    expect_val("r0_cnt", K_CNT, 32'd1);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
